// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshakes.
// Multiply is shift-add on operand magnitudes; divide is restoring, one bit per cycle.
// Both share a single 64-bit working register.
// Optional feature macro: MULDIV_FAST_MUL_EN. When defined, multiplies use a
// single-cycle 33x33 signed '*' product and skip the iterative phase.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_op1,
  input  logic [XLEN-1:0]  req_op2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [4:0]          r_cnt;
  logic [2*XLEN-1:0]   r_prod;      // mul: {hi, lo/multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     r_b;         // multiplicand / divisor magnitude
  logic [2:0]          r_op;
  logic                r_neg;       // result needs negation in FIX
  logic [XLEN-1:0]     r_resp_data;
  logic [TAG_W-1:0]    r_tag;

  // Request decode (only meaningful while idle)
  logic                w_accept;
  logic                w_is_div;
  logic                w_sgn1;
  logic                w_sgn2;
  logic                w_neg1;
  logic                w_neg2;
  logic [XLEN-1:0]     w_abs1;
  logic [XLEN-1:0]     w_abs2;
  logic                w_res_neg;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_data;
  logic                w_fast_mul;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_is_div   = req_op[2];
  // op1 is signed for everything except MULHU/DIVU/REMU
  assign w_sgn1     = (req_op != 3'b011) && (req_op != 3'b101) && (req_op != 3'b111);
  // op2 is signed for MUL/MULH/DIV/REM only
  assign w_sgn2     = (req_op == 3'b000) || (req_op == 3'b001) ||
                      (req_op == 3'b100) || (req_op == 3'b110);
  assign w_neg1     = w_sgn1 && req_op1[XLEN-1];
  assign w_neg2     = w_sgn2 && req_op2[XLEN-1];
  assign w_abs1     = w_neg1 ? -req_op1 : req_op1;
  assign w_abs2     = w_neg2 ? -req_op2 : req_op2;
  // Remainder follows the dividend's sign; products and quotients follow sign mismatch
  assign w_res_neg  = (w_is_div && req_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
  assign w_div_zero = w_is_div && (req_op2 == '0);
  assign w_div_ovf  = ((req_op == 3'b100) || (req_op == 3'b110)) &&
                      (req_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_op2 == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  // req_op[1] separates REM/REMU from DIV/DIVU
  assign w_special_data = w_div_zero ? (req_op[1] ? req_op1 : '1)
                                     : (req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_f1;
  logic signed [XLEN:0]     w_f2;
  logic signed [2*XLEN+1:0] w_fast_full;
  assign w_f1        = {w_sgn1 && req_op1[XLEN-1], req_op1};
  assign w_f2        = {w_sgn2 && req_op2[XLEN-1], req_op2};
  assign w_fast_full = w_f1 * w_f2;
  assign w_fast_mul  = !w_is_div;
`else
  assign w_fast_mul  = 1'b0;
`endif

  // One iteration of each algorithm
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_step;
  logic [XLEN:0]       w_div_trial;
  logic [2*XLEN-1:0]   w_div_step;

  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
  assign w_mul_step  = {w_mul_sum, r_prod[XLEN-1:1]};
  assign w_div_trial = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_b};
  assign w_div_step  = w_div_trial[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

  // Final sign correction and word selection
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_div_sel;
  logic [XLEN-1:0]     w_div_fix;
  logic [XLEN-1:0]     w_fix_data;

  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_div_sel  = r_op[1] ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
  assign w_div_fix  = r_neg ? -w_div_sel : w_div_sel;
  assign w_fix_data = r_op[2] ? w_div_fix
                    : ((r_op == 3'b000) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_special)       w_state_next = S_DONE;
          else if (w_fast_mul) w_state_next = S_FIX;
          else                 w_state_next = S_CALC;
        end
      end
      S_CALC:  if (r_cnt == 5'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iterations, result formation
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_prod      <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_resp_data <= '0;
      r_tag       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= req_op;
          r_tag  <= req_tag;
          r_b    <= w_abs2;
          r_neg  <= w_res_neg;
          r_cnt  <= '0;
          r_prod <= {{XLEN{1'b0}}, w_abs1};
          if (w_special) r_resp_data <= w_special_data;
`ifdef MULDIV_FAST_MUL_EN
          if (w_fast_mul) begin
            r_prod <= w_fast_full[2*XLEN-1:0];
            r_neg  <= 1'b0;
          end
`endif
        end
        S_CALC: begin
          r_cnt  <= r_cnt + 5'd1;
          r_prod <= r_op[2] ? w_div_step : w_mul_step;
        end
        S_FIX:   r_resp_data <= w_fix_data;
        default: ;
      endcase
    end
  end

  assign resp_data = r_resp_data;
  assign resp_tag  = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit integer math on the RV32M rules).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from the RV32M arithmetic rules
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int         ia, ib;
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // One full transaction: issue, measure latency, check result, retire
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input string name);
    int cyc;
    @(negedge clk);
    chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_op1 = a; req_op2 = b; req_tag = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op1 = $urandom; req_op2 = $urandom; req_tag = 5'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 100);
    chk({name, ".latency"}, 32'(cyc), 32'(exp_lat(op, a, b)));
    chk({name, ".data"}, resp_data, exp);
    chk({name, ".tag"}, 32'(resp_tag), 32'(tag));
    $display("txn %s op=%0d a=%h b=%h tag=%0d data=%h lat=%0d", name, op, a, b, tag, resp_data, cyc);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({name, ".retired"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hexp;
    logic        seen;
    int          cyc;

    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_op1 = '0; req_op2 = '0;
    req_tag = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready",  32'(req_ready),  32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.resp_data",  resp_data,       32'd0);
    chk("reset.resp_tag",   32'(resp_tag),   32'd0);
    rstn = 1'b1;

    // Directed vectors with hand-computed results
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, "MUL_7x-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, "MULH_min2");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, "MULHU_max2");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, "MULHSU_-1x2");
    run_op(3'd5, 32'd100,       32'd7,         5'd5,  32'd14,        "DIVU_100_7");
    run_op(3'd7, 32'd100,       32'd7,         5'd6,  32'd2,         "REMU_100_7");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, "DIV_-7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, "REM_-7_2");
    run_op(3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, "DIV_5_0");
    run_op(3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         "REMU_5_0");
    run_op(3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, "DIVU_5_0");
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0,         5'd12, 32'hFFFF_FFFB, "REM_-5_0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, "DIV_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         "REM_ovf");

    // Result held while consumer stalls; new requests are refused
    hexp = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_op1 = 32'h1234_5678; req_op2 = 32'h9ABC_DEF0; req_tag = 5'd9;
    @(posedge clk);
    #1;
    req_op = 3'd5; req_op1 = 32'd50; req_op2 = 32'd5; req_tag = 5'd30;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 100);
    chk("hold.arrive", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d.data", i),  resp_data,        hexp);
      chk($sformatf("hold%0d.tag", i),   32'(resp_tag),    32'd9);
      chk($sformatf("hold%0d.ready", i), 32'(req_ready),   32'd0);
    end
    $display("txn hold op=3 tag=9 data=%h held 10 cycles", resp_data);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("hold.no_second_accept", 32'(seen), 32'd0);
    chk("hold.idle_ready", 32'(req_ready), 32'd1);

    // Reset during the iterative phase abandons the operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_op1 = 32'hFFFF_FFFF; req_op2 = 32'd3; req_tag = 5'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst.req_ready",  32'(req_ready),  32'd1);
    chk("midrst.resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst.resp_data",  resp_data,       32'd0);
    chk("midrst.resp_tag",   32'(resp_tag),   32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("midrst.no_response", 32'(seen), 32'd0);
    $display("txn midrst abandoned DIVU, unit idle");
    run_op(3'd5, 32'd9, 32'd3, 5'h15, 32'd3, "DIVU_9_3_after_rst");

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tg;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      tg = 5'($urandom);
      run_op(op, a, b, tg, model(op, a, b), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
